// File: rtl/alu.sv
// rtl/alu.sv - Registered ALU, one operation per enabled cycle; ALU_SATURATE_EN selects saturating add/sub.
module alu #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       sel,
  input  logic             en,
  output logic [WIDTH-1:0] R,
  output logic             flag,
  output logic             out_valid
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] cmp;
  logic [WIDTH-1:0] res;
  logic             res_flag;

  always_comb begin
    sum      = {1'b0, A} + {1'b0, B};
    diff     = {1'b0, A} - {1'b0, B};
    // Two spare bits keep the compare vector legal at WIDTH=2, where R[2] does not exist.
    cmp      = '0;
    cmp[0]   = (A < B);
    cmp[1]   = (A == B);
    cmp[2]   = (A > B);
    res      = '0;
    res_flag = 1'b0;
    case (sel)
      3'b000: begin
        res_flag = sum[WIDTH];
`ifdef ALU_SATURATE_EN
        res      = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        res      = sum[WIDTH-1:0];
`endif
      end
      3'b001: begin
        res_flag = diff[WIDTH];
`ifdef ALU_SATURATE_EN
        res      = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        res      = diff[WIDTH-1:0];
`endif
      end
      3'b010: begin
        res      = A & B;
        res_flag = ((A & B) == '0);
      end
      3'b011: begin
        res      = A | B;
        res_flag = ((A | B) == '0);
      end
      3'b100: begin
        res      = A ^ B;
        res_flag = ((A ^ B) == '0);
      end
      3'b101: begin
        res      = cmp[WIDTH-1:0];
        res_flag = (A == B);
      end
      3'b110: begin
        res      = {A[WIDTH-2:0], 1'b0};
        res_flag = A[WIDTH-1];
      end
      default: begin
        res      = {1'b0, A[WIDTH-1:1]};
        res_flag = A[0];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R         <= '0;
      flag      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= en;
      if (en) begin
        R    <= res;
        flag <= res_flag;
      end
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - Scoreboard bench for alu at WIDTH=4 with directed vectors.
module tb_alu;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic [2:0] sel;
  logic       en;
  logic [3:0] R;
  logic       flag;
  logic       out_valid;

  logic [4:0] exp_q[$];
  logic [3:0] last_r;
  logic       last_f;
  int         n_cmp;
  int         n_err;

  alu #(.WIDTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .A(A),
    .B(B),
    .sel(sel),
    .en(en),
    .R(R),
    .flag(flag),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  // Monitor: every valid output pops one expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got R=%b flag=%b with nothing expected", R, flag);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        chk("result_R", R, e[4:1]);
        chk("result_flag", {3'b0, flag}, {3'b0, e[0]});
      end
    end
  end

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                       input logic [3:0] r, input logic f);
    A   = a;
    B   = b;
    sel = s;
    en  = 1'b1;
    exp_q.push_back({r, f});
    last_r = r;
    last_f = f;
    @(negedge clk);
  endtask

  task automatic idle();
    en = 1'b0;
    @(negedge clk);
    chk("idle_valid", {3'b0, out_valid}, 4'd0);
    chk("hold_R", R, last_r);
    chk("hold_flag", {3'b0, flag}, {3'b0, last_f});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    A     = '0;
    B     = '0;
    sel   = '0;
    last_r = '0;
    last_f = 1'b0;
    #2;
    chk("reset_R", R, 4'd0);
    chk("reset_flag", {3'b0, flag}, 4'd0);
    chk("reset_valid", {3'b0, out_valid}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(4'd3, 4'd2, 3'b000, 4'b0101, 1'b0);
    drive(4'd7, 4'd5, 3'b001, 4'b0010, 1'b0);
    drive(4'b1010, 4'b1100, 3'b010, 4'b1000, 1'b0);
    drive(4'b1010, 4'b1100, 3'b011, 4'b1110, 1'b0);
    drive(4'b1010, 4'b1100, 3'b100, 4'b0110, 1'b0);
    drive(4'b1010, 4'b0101, 3'b010, 4'b0000, 1'b1);
    drive(4'd5, 4'd5, 3'b101, 4'b0010, 1'b1);
    drive(4'd3, 4'd9, 3'b101, 4'b0001, 1'b0);
    drive(4'd9, 4'd3, 3'b101, 4'b0100, 1'b0);
    drive(4'b0011, 4'b1111, 3'b110, 4'b0110, 1'b0);
    drive(4'b1001, 4'b0000, 3'b110, 4'b0010, 1'b1);
    drive(4'b1000, 4'b1111, 3'b111, 4'b0100, 1'b0);
    drive(4'b0011, 4'b0000, 3'b111, 4'b0001, 1'b1);
    drive(4'b0000, 4'b0000, 3'b011, 4'b0000, 1'b1);
    drive(4'b0110, 4'b0110, 3'b100, 4'b0000, 1'b1);
`ifdef ALU_SATURATE_EN
    drive(4'd15, 4'd1, 3'b000, 4'b1111, 1'b1);
    drive(4'd2, 4'd5, 3'b001, 4'b0000, 1'b1);
`else
    drive(4'd15, 4'd1, 3'b000, 4'b0000, 1'b1);
    drive(4'd2, 4'd5, 3'b001, 4'b1101, 1'b1);
`endif
    drive(4'd9, 4'd4, 3'b000, 4'b1101, 1'b0);

    for (int i = 0; i < 3; i++) idle();

    for (int i = 0; i < 3; i++) begin
      drive(4'(i + 1), 4'd1, 3'b000, 4'(i + 2), 1'b0);
      idle();
    end

    // Reset mid-cycle with an operation presented: it must never emerge.
    drive(4'd6, 4'd5, 3'b011, 4'b0111, 1'b0);
    A   = 4'd1;
    B   = 4'd1;
    sel = 3'b000;
    en  = 1'b1;
    #2;
    rst_n = 1'b0;
    en    = 1'b0;
    #1;
    chk("async_reset_R", R, 4'd0);
    chk("async_reset_flag", {3'b0, flag}, 4'd0);
    chk("async_reset_valid", {3'b0, out_valid}, 4'd0);
    @(negedge clk);
    chk("held_reset_R", R, 4'd0);
    chk("held_reset_valid", {3'b0, out_valid}, 4'd0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_R", R, 4'd0);
    chk("post_reset_flag", {3'b0, flag}, 4'd0);
    chk("post_reset_valid", {3'b0, out_valid}, 4'd0);
    drive(4'd12, 4'd3, 3'b001, 4'b1001, 1'b0);
    idle();

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_results: got %0d outstanding, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
